spi_loopback_checker: RTL

- Sits downstream of spi_master, alongside the 1 Hz trigger logic in the board top.
- Snoops each transaction's start/tx_data and the master's done/rx_data, and scores each returned byte against the byte sent on the MOSI→MISO loopback wire.
- Keeps saturating pass/fail counts, sticky error flags and a 4-bit LED status word, replacing the raw rx_data-on-LEDs debug path.

---
 rtl/spi_chk_pkg.sv | 14 +
 rtl/spi_loopback_checker_sat_counter.sv | 22 ++
 rtl/spi_loopback_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spi_chk_pkg.sv
// Shared types and status bit positions for the SPI loopback checker.
package spi_chk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int STATUS_ERR_BIT  = 3;
  localparam int STATUS_FAIL_BIT = 2;
  localparam int STATUS_OK_BIT   = 1;
  localparam int STATUS_HB_BIT   = 0;

endpackage

// File: rtl/spi_loopback_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/spi_loopback_checker.sv
// Scores each SPI loopback byte against the byte sent; keeps counts, sticky flags, LED word.
// Optional macro SPI_CHK_TIMEOUT_EN adds a start-to-done timeout.
//
// state | meaning
// IDLE  | no transaction outstanding
// WAIT  | start seen, waiting for done (expected byte latched)
module spi_loopback_checker
  import spi_chk_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic                  last_ok,
  output logic                  protocol_err,
  output logic                  timeout,
  output logic [3:0]            status
);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] expected, expected_nx;
  logic                  last_ok_nx, perr_nx, tmo_q, tmo_nx, heartbeat, hb_nx;
  logic                  pass_inc, fail_inc, match, expired;

  assign match = (rx_data == expected);

`ifdef SPI_CHK_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  logic [WAIT_W-1:0] wait_cnt;
  logic              entering;

  assign expired  = (state == WAIT) && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign entering = start && ((state == IDLE) || done);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear || entering) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES == 0);
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    expected_nx = expected;
    last_ok_nx  = last_ok;
    perr_nx     = protocol_err;
    tmo_nx      = tmo_q;
    hb_nx       = heartbeat;
    pass_inc    = 1'b0;
    fail_inc    = 1'b0;
    if (clear) begin
      state_nx    = IDLE;
      expected_nx = '0;
      last_ok_nx  = 1'b0;
      perr_nx     = 1'b0;
      tmo_nx      = 1'b0;
      hb_nx       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            expected_nx = tx_data;
            state_nx    = WAIT;
          end else if (done) begin
            perr_nx = 1'b1;
          end
        end
        WAIT: begin
          if (done) begin
            pass_inc   = match;
            fail_inc   = !match;
            last_ok_nx = match;
            hb_nx      = !heartbeat;
            // A simultaneous start opens the next transaction immediately.
            if (start) expected_nx = tx_data;
            else       state_nx    = IDLE;
          end else if (expired) begin
            fail_inc   = 1'b1;
            last_ok_nx = 1'b0;
            tmo_nx     = 1'b1;
            hb_nx      = !heartbeat;
            state_nx   = IDLE;
          end else if (start) begin
            perr_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      expected     <= '0;
      last_ok      <= 1'b0;
      protocol_err <= 1'b0;
      tmo_q        <= 1'b0;
      heartbeat    <= 1'b0;
    end else begin
      state        <= state_nx;
      expected     <= expected_nx;
      last_ok      <= last_ok_nx;
      protocol_err <= perr_nx;
      tmo_q        <= tmo_nx;
      heartbeat    <= hb_nx;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pass (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .inc     (pass_inc),
    .clr     (clear),
    .count   (pass_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_fail (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .inc     (fail_inc),
    .clr     (clear),
    .count   (fail_cnt)
  );

  assign timeout = tmo_q;

  assign status[STATUS_ERR_BIT]  = protocol_err | tmo_q;
  assign status[STATUS_FAIL_BIT] = |fail_cnt;
  assign status[STATUS_OK_BIT]   = last_ok;
  assign status[STATUS_HB_BIT]   = heartbeat;

endmodule
